// File: rtl/bus_fabric.sv
// bus_fabric: system-bus interconnect between the CPU data port and NSLV
// memory-mapped slaves. Decodes each access against per-slave base/mask
// windows, registers the request toward the selected slave, waits on that
// slave's ready with a watchdog, and returns registered read data plus a
// one-cycle completion/error pulse.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   m_addr/m_wdata       master address and write data
//   m_rd/m_we            master read request / byte write enables (write wins)
//   m_rdata/m_ready/m_err registered read data, completion pulse, error pulse
//   s_sel                registered one-hot slave select
//   s_addr/s_wdata       registered address / write data to all slaves
//   s_rd/s_we            registered read strobe / byte enables (qualified by s_sel)
//   s_rdata/s_ready      flattened slave read data / per-slave ready
//   err_addr/err_cnt     address of latest errored access, saturating error count
module bus_fabric #(
    parameter int unsigned          NSLV     = 16,
    parameter int unsigned          AW       = 32,
    parameter int unsigned          DW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0]   SLV_MASK = '0,
    parameter int unsigned          TIMEOUT  = 15,
    parameter int unsigned          ECW      = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [AW-1:0]        m_addr,
    input  logic [DW-1:0]        m_wdata,
    input  logic                 m_rd,
    input  logic [DW/8-1:0]      m_we,
    output logic [DW-1:0]        m_rdata,
    output logic                 m_ready,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_sel,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    output logic                 s_rd,
    output logic [DW/8-1:0]      s_we,
    input  logic [NSLV*DW-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready,
    output logic [AW-1:0]        err_addr,
    output logic [ECW-1:0]       err_cnt
);

    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   sel_idx;

    logic            req_c;
    logic            is_write_c;
    logic            hit_c;
    logic [SW-1:0]   hit_idx_c;
    logic [NSLV-1:0] hit_oh_c;
    logic            sel_ready_c;
    logic [DW-1:0]   sel_rdata_c;
    logic [ECW-1:0]  err_cnt_inc_c;

    assign is_write_c = |m_we;
    assign req_c      = m_rd | is_write_c;

    // Address decode; scanning from the top lets the lowest-index hit win.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        hit_oh_c  = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*AW +: AW]) ==
                (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
                hit_c       = 1'b1;
                hit_idx_c   = SW'(i);
                hit_oh_c    = '0;
                hit_oh_c[i] = 1'b1;
            end
        end
    end

    // Only the selected slave's handshake and data are observed.
    assign sel_ready_c = s_ready[sel_idx];
    assign sel_rdata_c = s_rdata[sel_idx*DW +: DW];

    assign err_cnt_inc_c = (&err_cnt) ? err_cnt : err_cnt + ECW'(1);

    // Access sequencer: IDLE samples, ACCESS waits on ready/watchdog, RESP pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_idx  <= '0;
            m_rdata  <= '0;
            m_ready  <= 1'b0;
            m_err    <= 1'b0;
            s_sel    <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_rd     <= 1'b0;
            s_we     <= '0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c) begin
                        if (hit_c) begin
                            s_sel   <= hit_oh_c;
                            sel_idx <= hit_idx_c;
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                            s_we    <= m_we;
                            s_rd    <= ~is_write_c;
                            cnt     <= '0;
                            state   <= ACCESS;
                        end else begin
                            err_addr <= m_addr;
                            if (!is_write_c) m_rdata <= '1;
                            m_ready  <= 1'b1;
                            m_err    <= 1'b1;
                            err_cnt  <= err_cnt_inc_c;
                            state    <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is checked first so a same-cycle timeout loses.
                    if (sel_ready_c) begin
                        if (s_rd) m_rdata <= sel_rdata_c;
                        m_ready <= 1'b1;
                        s_sel   <= '0;
                        s_rd    <= 1'b0;
                        s_we    <= '0;
                        state   <= RESP;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        err_addr <= s_addr;
                        if (s_rd) m_rdata <= '1;
                        m_ready  <= 1'b1;
                        m_err    <= 1'b1;
                        err_cnt  <= err_cnt_inc_c;
                        s_sel    <= '0;
                        s_rd     <= 1'b0;
                        s_we     <= '0;
                        state    <= RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    // Turnaround cycle: the request is not sampled here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
